// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle MIPS main control FSM with memory-ready stalls.
// Optional performance counters are enabled by defining MC_CTRL_PERF_EN.
module mc_ctrl_fsm #(
  parameter int OP_W = 6,
  parameter int ST_W = 4
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic [OP_W-1:0] Op,
  input  logic            MemReady,
  output logic            PCWrite,
  output logic            PCWriteCond,
  output logic            IorD,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            MemtoReg,
  output logic            RegDst,
  output logic            RegWrite,
  output logic            ALUSrcA,
  output logic [1:0]      ALUSrcB,
  output logic [1:0]      ALUOp,
  output logic [1:0]      PCSource,
  output logic            Illegal,
  output logic [ST_W-1:0] State
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [31:0]     CycleCnt,
  output logic [31:0]     InstrCnt
`endif
);
  typedef enum logic [ST_W-1:0] {
    RST, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    RTYPE_EX, RTYPE_WB, BEQ, JUMP, ADDI_EX, ADDI_WB, ILL
  } state_e;

  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'b100011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'b101011);
  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'b000000);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'b000100);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'b000010);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'b001000);

  state_e          r_state, w_next;
  logic [OP_W-1:0] r_op;

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      r_state <= RST;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == DECODE) r_op <= Op;
    end

  assign State = r_state;

  always_comb begin
    w_next      = RST;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    Illegal     = 1'b0;
    case (r_state)
      RST: w_next = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = MemReady;
        PCWrite = MemReady;
        w_next  = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        w_next  = (Op == OP_LW || Op == OP_SW) ? MEMADR :
                  (Op == OP_R)                 ? RTYPE_EX :
                  (Op == OP_BEQ)               ? BEQ :
                  (Op == OP_J)                 ? JUMP :
                  (Op == OP_ADDI)              ? ADDI_EX : ILL;
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (r_op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        w_next  = MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
        w_next   = FETCH;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        w_next   = MemReady ? FETCH : MEMWR;
      end
      RTYPE_EX: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        w_next  = RTYPE_WB;
      end
      RTYPE_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        w_next   = FETCH;
      end
      BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        w_next      = FETCH;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        w_next   = FETCH;
      end
      ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = ADDI_WB;
      end
      ADDI_WB: begin
        RegWrite = 1'b1;
        w_next   = FETCH;
      end
      ILL: begin
        Illegal = 1'b1;
        w_next  = FETCH;
      end
      default: w_next = RST;
    endcase
  end

`ifdef MC_CTRL_PERF_EN
  // A FETCH stall is not a return to FETCH, so it is excluded from InstrCnt.
  logic w_retire;
  assign w_retire = (w_next == FETCH) && (r_state != RST) && (r_state != FETCH);

  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      CycleCnt <= '0;
      InstrCnt <= '0;
    end else begin
      if (r_state != RST) CycleCnt <= CycleCnt + 32'd1;
      if (w_retire) InstrCnt <= InstrCnt + 32'd1;
    end
`endif
endmodule
